// File: rtl/ulpb_tx_feeder_if.sv
// Signal bundle for ulpb_tx_feeder: the layer-side FIFO/control signals and the node TX handshake.
// The master modport is the feeder's view. The slave modport is the layer controller / node view.
interface ulpb_tx_feeder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 3
);
    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  FULL;
    logic [PTR_WIDTH:0]    COUNT;
    logic [ADDR_WIDTH-1:0] MSG_ADDR;
    logic                  MSG_PRIORITY;
    logic                  START;
    logic                  BUSY;
    logic                  DONE;
    logic                  RESULT;
    logic [ADDR_WIDTH-1:0] TX_ADDR;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_REQ;
    logic                  TX_ACK;
    logic                  TX_PEND;
    logic                  PRIORITY;
    logic                  TX_SUCC;
    logic                  TX_FAIL;
    logic                  TX_RESP_ACK;

    modport master (
        input  WR_EN, WR_DATA, MSG_ADDR, MSG_PRIORITY, START, TX_ACK, TX_SUCC, TX_FAIL,
        output FULL, COUNT, BUSY, DONE, RESULT, TX_ADDR, TX_DATA, TX_REQ, TX_PEND,
               PRIORITY, TX_RESP_ACK
    );

    modport slave (
        output WR_EN, WR_DATA, MSG_ADDR, MSG_PRIORITY, START, TX_ACK, TX_SUCC, TX_FAIL,
        input  FULL, COUNT, BUSY, DONE, RESULT, TX_ADDR, TX_DATA, TX_REQ, TX_PEND,
               PRIORITY, TX_RESP_ACK
    );
endinterface

// File: rtl/ulpb_tx_feeder.sv
// ulpb_tx_feeder: buffers words in a local FIFO and streams one message per START
// to a ulpb_node32 TX port. Each word uses a 4-phase REQ/ACK handshake. The node's
// SUCC/FAIL response is acknowledged with TX_RESP_ACK.
// Optional feature macro: ULPB_TX_RETRY_EN. When it is defined, a failed message
// is resent up to MAX_RETRY times.
module ulpb_tx_feeder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int MAX_RETRY  = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    ulpb_tx_feeder_if.master bus
);
    typedef logic [PTR_WIDTH:0]   cnt_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    localparam cnt_t FullCnt = cnt_t'(DEPTH);
    localparam cnt_t OneCnt  = cnt_t'(1);

    if (DEPTH != (1 << PTR_WIDTH) || MAX_RETRY < 0) begin : g_cfg_check
        $error("ulpb_tx_feeder: DEPTH must equal 2**PTR_WIDTH and MAX_RETRY must be >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_ACKLO,
        S_RESP,
        S_RCLR
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    ptr_t                  wptr_q, wptr_d;
    ptr_t                  rptr_q, rptr_d;
    cnt_t                  count_q, count_d;
    cnt_t                  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_q, req_d;
    logic                  pend_q, pend_d;
    logic                  prio_q, prio_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  result_q, result_d;
    logic                  rack_q, rack_d;
    logic                  full;
    logic                  push;
    logic                  pop;

`ifdef ULPB_TX_RETRY_EN
    localparam int RetryW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    ptr_t              snap_q, snap_d;
    cnt_t              len_q, len_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              free;
`endif

    assign full = (count_q == FullCnt);
    assign push = bus.WR_EN && !full;

    assign bus.FULL        = full;
    assign bus.COUNT       = count_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.RESULT      = result_q;
    assign bus.TX_ADDR     = addr_q;
    assign bus.TX_DATA     = data_q;
    assign bus.TX_REQ      = req_q;
    assign bus.TX_PEND     = pend_q;
    assign bus.PRIORITY    = prio_q;
    assign bus.TX_RESP_ACK = rack_q;

    // FIFO storage write port. The LOAD state reads the head word combinationally.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= bus.WR_DATA;
        end
    end

    // FIFO write pointer and occupancy.
    always_comb begin
        wptr_d = push ? wptr_q + ptr_t'(1) : wptr_q;
`ifdef ULPB_TX_RETRY_EN
        // Slots stay occupied until the whole message is retired, so that a retry can re-read them.
        count_d = count_q + (push ? OneCnt : '0) - (free ? len_q : '0);
`else
        case ({push, pop})
            2'b10:   count_d = count_q + OneCnt;
            2'b01:   count_d = count_q - OneCnt;
            default: count_d = count_q;
        endcase
`endif
    end

    // Message FSM: next state, handshake outputs, and read-pointer movement.
    always_comb begin
        state_d  = state_q;
        rptr_d   = rptr_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        data_d   = data_q;
        req_d    = req_q;
        pend_d   = pend_q;
        prio_d   = prio_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        rack_d   = rack_q;
        pop      = 1'b0;
`ifdef ULPB_TX_RETRY_EN
        snap_d   = snap_q;
        len_d    = len_q;
        retry_d  = retry_q;
        free     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.START && count_q != '0) begin
                    rem_d   = count_q;
                    addr_d  = bus.MSG_ADDR;
                    prio_d  = bus.MSG_PRIORITY;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
`ifdef ULPB_TX_RETRY_EN
                    snap_d  = rptr_q;
                    len_d   = count_q;
                    retry_d = '0;
`endif
                end
            end
            S_LOAD: begin
                data_d  = mem_q[rptr_q];
                pend_d  = (rem_q > OneCnt);
                req_d   = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.TX_ACK) begin
                    req_d   = 1'b0;
                    pop     = 1'b1;
                    rem_d   = rem_q - OneCnt;
                    state_d = S_ACKLO;
                end else if (bus.TX_FAIL) begin
                    req_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_ACKLO: begin
                if (bus.TX_FAIL) begin
                    state_d = S_RESP;
                end else if (!bus.TX_ACK) begin
                    state_d = (rem_q != '0) ? S_LOAD : S_RESP;
                end
            end
            S_RESP: begin
                if (bus.TX_SUCC || bus.TX_FAIL) begin
                    rack_d   = 1'b1;
                    result_d = bus.TX_SUCC && !bus.TX_FAIL;
                    state_d  = S_RCLR;
                end
            end
            S_RCLR: begin
`ifdef ULPB_TX_RETRY_EN
                if (!bus.TX_SUCC && !bus.TX_FAIL) begin
                    rack_d = 1'b0;
                    if (!result_q && retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        rptr_d  = snap_q;
                        rem_d   = len_q;
                        state_d = S_LOAD;
                    end else begin
                        // Retire the message. The read pointer may be mid-message after a final fail.
                        rptr_d  = snap_q + ptr_t'(len_q);
                        rem_d   = '0;
                        free    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        prio_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
`else
                // Unsent words of a failed message drain here, one per cycle, before DONE.
                if (rem_q != '0) begin
                    pop   = 1'b1;
                    rem_d = rem_q - OneCnt;
                end
                if (!bus.TX_SUCC && !bus.TX_FAIL && rem_q == '0) begin
                    rack_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    prio_d  = 1'b0;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
    end

    // State and output registers. The reset is asynchronous, so TX_REQ drops immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            req_q    <= 1'b0;
            pend_q   <= 1'b0;
            prio_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            rack_q   <= 1'b0;
`ifdef ULPB_TX_RETRY_EN
            snap_q   <= '0;
            len_q    <= '0;
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            req_q    <= req_d;
            pend_q   <= pend_d;
            prio_q   <= prio_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rack_q   <= rack_d;
`ifdef ULPB_TX_RETRY_EN
            snap_q   <= snap_d;
            len_q    <= len_d;
            retry_q  <= retry_d;
`endif
        end
    end
endmodule
